// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/DM memory arbiter: FSM states, grant codes and data width.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    G_NONE = 2'b00,
    G_IF   = 2'b01,
    G_DM   = 2'b10
  } grant_t;

  localparam int unsigned WORD_W = 32;

endpackage

// File: rtl/imem_dmem_arbiter.sv
// Serialises instruction-fetch and data-memory requests onto one single-port memory
// handshake; DM has priority except when IF has waited MAX_DSTREAK data grants.
module imem_dmem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW          = 16,
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [AW-1:0]     if_addr,
  output logic [WORD_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [3:0]        dm_be,
  input  logic [AW-1:0]     dm_addr,
  input  logic [WORD_W-1:0] dm_wdata,
  output logic [WORD_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [AW-1:0]     mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [1:0]        grant
);

  localparam logic [3:0] DSTREAK_MAX = 4'(MAX_DSTREAK);

  state_t     state;
  grant_t     grant_q;
  logic [3:0] dstreak;
  logic       if_wins;

  // IF only overrides a pending DM request once the data streak has saturated
  assign if_wins = if_req && (!dm_req || (dstreak == DSTREAK_MAX));
  assign grant   = grant_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      grant_q   <= G_NONE;
      dstreak   <= '0;
      if_rdata  <= '0;
      if_done   <= 1'b0;
      dm_rdata  <= '0;
      dm_done   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (if_req || dm_req) begin
            mem_req <= 1'b1;
            state   <= BUSY;
            if (if_wins) begin
              grant_q   <= G_IF;
              mem_we    <= 1'b0;
              mem_be    <= '1;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
              dstreak   <= '0;
            end else begin
              grant_q   <= G_DM;
              mem_we    <= dm_we;
              mem_be    <= dm_be;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
              if (!if_req) begin
                dstreak <= '0;
              end else if (dstreak != DSTREAK_MAX) begin
                dstreak <= dstreak + 4'd1;
              end
            end
          end
        end
        BUSY: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= RESP;
            if (grant_q == G_IF) begin
              if_rdata <= mem_rdata;
              if_done  <= 1'b1;
            end else begin
              if (!mem_we) begin
                dm_rdata <= mem_rdata;
              end
              dm_done <= 1'b1;
            end
          end
        end
        RESP: begin
          if_done <= 1'b0;
          dm_done <= 1'b0;
          grant_q <= G_NONE;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
Shares the single-port on-chip memory between the pipeline's instruction-fetch (IF) port and data-memory (MEM-stage) port. It serialises requests through one memory handshake and returns read data plus a one-cycle done pulse to the winning requester. The IF and MEM stages use the done pulses to generate their stalls. It sits inside Top, between the pipeline stages and the memory wrapper.

Parameters:
AW, 16, byte-address width of all address ports
MAX_DSTREAK, 4, max consecutive data grants while if_req is pending before IF is forced a grant (1..15)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
if_req  in  1  IF read request; held until if_done
if_addr  in  AW  IF word address (bits [1:0] ignored)
if_rdata  out  32  fetched instruction; valid while if_done=1, then held
if_done  out  1  one-cycle completion pulse to IF
dm_req  in  1  data request; held with fields stable until dm_done
dm_we  in  1  1 = write, 0 = read
dm_be  in  4  byte enables for writes
dm_addr  in  AW  data address
dm_wdata  in  32  write data
dm_rdata  out  32  read data; valid while dm_done=1, then held
dm_done  out  1  one-cycle completion pulse to MEM stage
mem_req  out  1  memory request; held until mem_ack
mem_we  out  1  memory write enable
mem_be  out  4  memory byte enables
mem_addr  out  AW  memory address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, valid when mem_ack=1
mem_ack  in  1  memory completion, single-cycle pulse, arrives >=1 cycle after mem_req rises
grant  out  2  debug: 00 none, 01 IF, 10 DM

Behaviour:
- All outputs are registered. Reset values: all 0, including rdata registers and the streak counter. FSM is in IDLE.
- FSM states: IDLE, BUSY, RESP.
- IDLE, no request: stay in IDLE.
- IDLE, any request: pick a winner and latch its fields into the mem_* registers. Set mem_req=1 and the grant code. Go to BUSY.
- IF requests always use mem_we=0 and mem_be=4'hF.
- BUSY: hold mem_* stable. When mem_ack=1: capture mem_rdata into the winner's rdata register, pulse the winner's done, clear mem_req, go to RESP.
- mem_ack arriving while not in BUSY is ignored.
- RESP: done deasserts; grant=00. Go to IDLE unconditionally. The requester's req may still be high this cycle and must not be re-sampled.
- Timing with a 1-cycle memory: req seen in cycle N; mem_req high in N+1; ack in N+1; done in N+2; the next request can be sampled in N+3. Minimum 3 cycles per access.
- Priority: DM wins over IF (DM belongs to the older instruction). Exception: when dstreak==MAX_DSTREAK and if_req=1, IF wins.
- Starvation counter dstreak:
  - increments on each DM grant made while if_req=1, saturating at MAX_DSTREAK;
  - clears on any IF grant;
  - clears on a DM grant made while if_req=0.
- Writes: dm_rdata is not updated; dm_done still pulses.
- Address, be and wdata pass through unmodified.
- A requester dropping req while BUSY is a protocol violation. The transaction still completes and done still pulses.
- Reset mid-transaction: immediate return to IDLE, mem_req=0, the in-flight access is abandoned, and no done pulse is issued.

Decomposition:
- Package mem_arb_pkg holds:
  - state_t enum {IDLE, BUSY, RESP};
  - grant_t enum {G_NONE=2'b00, G_IF=2'b01, G_DM=2'b10};
  - localparam WORD_W=32.
- No sub-module: the FSM, streak counter and output registers all live in one module.

Test Plan:
- Reset: hold rst=0 for 3 cycles with both reqs high -> all outputs 0, grant=00; after rst=1 the first grant occurs on the next edge.
- IF alone, if_addr=16'h0040, memory acks 1 cycle after request with rdata=32'h00500093 -> if_done pulses exactly once, 2 cycles after request sample; if_rdata=32'h00500093.
- DM write, dm_addr=16'h0100, be=4'b0011, wdata=32'hDEADBEEF -> mem_we=1, mem_be=4'b0011, mem_wdata=32'hDEADBEEF, dm_done pulses once, dm_rdata unchanged.
- Simultaneous if_req and dm_req in IDLE -> grant=10 first, dm_done first, then IF served on the next IDLE sample.
- dm_req continuously reasserted while if_req stays high, MAX_DSTREAK=4 -> exactly 4 DM grants, then 1 IF grant; dstreak returns to 0.
- Memory ack delayed 5 cycles, rst pulsed low in the 3rd BUSY cycle -> mem_req drops immediately, neither done pulses, a late mem_ack is ignored, and the FSM is in IDLE.
